// File: rtl/hamming_cw_deserializer.sv
// Bit-serial to parallel codeword collector with a one-entry valid/ready output buffer.
// Frames start on sof; a long inter-bit gap or a fresh sof mid-frame aborts the partial frame.
module hamming_cw_deserializer #(
  parameter int unsigned CW_WIDTH  = 8,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 sof,
  input  logic                 clr_stats,
  output logic [CW_WIDTH-1:0]  cw_data,
  output logic                 cw_valid,
  input  logic                 cw_ready,
  output logic                 busy,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] frame_err_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  localparam int unsigned IDX_W = $clog2(CW_WIDTH);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(CW_WIDTH - 1);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [0:0]           state_q, state_d;
  logic [CW_WIDTH-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 complete, abort;
  logic [CW_WIDTH-1:0]  done_word;

  logic [CW_WIDTH-1:0]  cw_data_q;
  logic                 cw_valid_q;
  logic                 overrun_q;
  logic [CNT_WIDTH-1:0] ferr_q, drop_q;
  logic                 load, drop;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    complete  = 1'b0;
    abort     = 1'b0;
    done_word = shift_q;
    case (state_q)
      IDLE: begin
        if (bit_valid && sof) begin
          shift_d    = '0;
          shift_d[0] = bit_in;
          idx_d      = IDX_W'(1);
          timer_d    = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid && sof) begin
          // Restart on the new sof bit; the old partial frame counts as an error.
          abort      = 1'b1;
          shift_d    = '0;
          shift_d[0] = bit_in;
          idx_d      = IDX_W'(1);
          timer_d    = '0;
        end else if (bit_valid) begin
          shift_d[idx_q] = bit_in;
          idx_d          = idx_q + IDX_W'(1);
          timer_d        = '0;
          if (idx_q == LAST_IDX) begin
            complete  = 1'b1;
            done_word = shift_d;
            shift_d   = '0;
            idx_d     = '0;
            state_d   = IDLE;
          end
        end else if (timer_q == TMR_LAST) begin
          abort   = 1'b1;
          shift_d = '0;
          idx_d   = '0;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load = complete && (!cw_valid_q || cw_ready);
  assign drop = complete && cw_valid_q && !cw_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_data_q  <= '0;
      cw_valid_q <= 1'b0;
    end else if (load) begin
      cw_data_q  <= done_word;
      cw_valid_q <= 1'b1;
    end else if (cw_valid_q && cw_ready) begin
      cw_valid_q <= 1'b0;
    end
  end

  // Clear takes priority over any same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
      ferr_q    <= '0;
      drop_q    <= '0;
    end else if (clr_stats) begin
      overrun_q <= 1'b0;
      ferr_q    <= '0;
      drop_q    <= '0;
    end else begin
      if (abort && ferr_q != CNT_MAX) ferr_q <= ferr_q + CNT_WIDTH'(1);
      if (drop) begin
        overrun_q <= 1'b1;
        if (drop_q != CNT_MAX) drop_q <= drop_q + CNT_WIDTH'(1);
      end
    end
  end

  assign cw_data       = cw_data_q;
  assign cw_valid      = cw_valid_q;
  assign busy          = (state_q == SHIFT);
  assign overrun       = overrun_q;
  assign frame_err_cnt = ferr_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_hamming_cw_deserializer.sv
// Scoreboard bench: a frame-level reference model queues expected codewords, a negedge
// monitor pops them on each handshake and cross-checks status outputs.
module tb_hamming_cw_deserializer;

  localparam int unsigned CW  = 8;
  localparam int unsigned TO  = 4;
  localparam int unsigned CNW = 2;
  localparam int          CMAX = (1 << CNW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0, bit_valid = 1'b0, sof = 1'b0, clr_stats = 1'b0, cw_ready = 1'b0;
  logic [CW-1:0]  cw_data;
  logic           cw_valid, busy, overrun;
  logic [CNW-1:0] frame_err_cnt, drop_cnt;

  int checks = 0;
  int failures = 0;

  hamming_cw_deserializer #(
    .CW_WIDTH (CW),
    .TIMEOUT  (TO),
    .CNT_WIDTH(CNW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .sof          (sof),
    .clr_stats    (clr_stats),
    .cw_data      (cw_data),
    .cw_valid     (cw_valid),
    .cw_ready     (cw_ready),
    .busy         (busy),
    .overrun      (overrun),
    .frame_err_cnt(frame_err_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame as a bit count plus accumulated word, buffer as a queue.
  logic [7:0] exp_q[$];
  int         m_cnt = 0, m_idle = 0, m_ferr = 0, m_drop = 0;
  logic [7:0] m_word = 8'h00;
  logic       m_in = 1'b0, m_full = 1'b0, m_ovr = 1'b0;

  int         n_cnt, n_idle, n_err, n_drp;
  logic [7:0] n_word, n_done_word;
  logic       n_in, n_done, n_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_cnt <= 0; m_idle <= 0; m_ferr <= 0; m_drop <= 0;
      m_word <= 8'h00; m_in <= 1'b0; m_full <= 1'b0; m_ovr <= 1'b0;
    end else begin
      n_cnt = m_cnt; n_idle = m_idle; n_word = m_word; n_in = m_in;
      n_err = 0; n_drp = 0; n_done = 1'b0; n_done_word = 8'h00;
      if (bit_valid && sof) begin
        if (m_in) n_err = 1;
        n_in = 1'b1; n_word = {7'd0, bit_in}; n_cnt = 1; n_idle = 0;
      end else if (bit_valid && m_in) begin
        n_word = m_word | (8'(bit_in) << m_cnt);
        n_cnt  = m_cnt + 1;
        n_idle = 0;
        if (n_cnt == CW) begin
          n_done = 1'b1; n_done_word = n_word;
          n_in = 1'b0; n_cnt = 0; n_word = 8'h00;
        end
      end else if (!bit_valid && m_in) begin
        n_idle = m_idle + 1;
        if (n_idle == TO) begin
          n_err = 1; n_in = 1'b0; n_cnt = 0; n_word = 8'h00; n_idle = 0;
        end
      end
      n_full = m_full;
      if (m_full && cw_ready) n_full = 1'b0;
      if (n_done) begin
        if (!m_full || cw_ready) begin
          exp_q.push_back(n_done_word);
          n_full = 1'b1;
        end else begin
          n_drp = 1;
        end
      end
      m_cnt <= n_cnt; m_idle <= n_idle; m_word <= n_word; m_in <= n_in; m_full <= n_full;
      if (clr_stats) begin
        m_ferr <= 0; m_drop <= 0; m_ovr <= 1'b0;
      end else begin
        m_ferr <= (m_ferr + n_err > CMAX) ? CMAX : m_ferr + n_err;
        m_drop <= (m_drop + n_drp > CMAX) ? CMAX : m_drop + n_drp;
        if (n_drp != 0) m_ovr <= 1'b1;
      end
    end
  end

  // Monitor: compare status every cycle, pop the scoreboard on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(m_in));
      chk("cw_valid", 32'(cw_valid), 32'(m_full));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("frame_err_cnt", 32'(frame_err_cnt), 32'(m_ferr));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (cw_valid) begin
        if (exp_q.size() == 0) begin
          chk("cw_data_unexpected", 32'(cw_data), 32'hFFFF_FFFF);
        end else begin
          chk("cw_data", 32'(cw_data), 32'(exp_q[0]));
          if (cw_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic bv, input logic b, input logic s, input logic rdy,
                      input logic clr);
    bit_valid = bv; bit_in = b; sof = s; cw_ready = rdy; clr_stats = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic rdy_body, input logic rdy_last);
    for (int i = 0; i < CW; i++)
      step(1'b1, w[i], i == 0, (i == CW - 1) ? rdy_last : rdy_body, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(cw_valid), 32'd0);
    chk("reset_data", 32'(cw_data), 32'd0);
    rst = 1'b0;
    idle(1, 1'b1);

    // Basic frame with ready held high.
    send_frame(8'hB4, 1'b1, 1'b1);
    chk("t1_valid", 32'(cw_valid), 32'd1);
    chk("t1_data", 32'(cw_data), 32'hB4);
    chk("t1_busy", 32'(busy), 32'd0);
    idle(1, 1'b1);
    chk("t1_valid_clear", 32'(cw_valid), 32'd0);

    // Second codeword dropped on a full buffer.
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("t2_data", 32'(cw_data), 32'h3C);
    chk("t2_drop", 32'(drop_cnt), 32'd1);
    chk("t2_overrun", 32'(overrun), 32'd1);
    idle(1, 1'b1);
    chk("t2_valid", 32'(cw_valid), 32'd0);
    chk("t2_data_kept", 32'(cw_data), 32'h3C);

    // Completion coincides with consumption of the held word.
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("t3_valid", 32'(cw_valid), 32'd1);
    chk("t3_data", 32'(cw_data), 32'h5A);
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    idle(1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_overrun", 32'(overrun), 32'd0);

    // sof mid-frame restarts.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1);
    chk("t4_ferr", 32'(frame_err_cnt), 32'd1);
    chk("t4_data", 32'(cw_data), 32'h81);
    chk("t4_drop", 32'(drop_cnt), 32'd0);
    idle(1, 1'b1);

    // Inter-bit timeout.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'(i), 1'b0, 1'b1, 1'b0);
    idle(TO - 1, 1'b1);
    chk("t5_busy_before_timeout", 32'(busy), 32'd1);
    idle(1, 1'b1);
    chk("t5_ferr", 32'(frame_err_cnt), 32'd2);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(cw_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_ignored", 32'(busy), 32'd0);

    // Saturation, clear, reset mid-frame.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(TO, 1'b1);
    end
    chk("t6_sat", 32'(frame_err_cnt), 32'(CMAX));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_clr", 32'(frame_err_cnt), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_data", 32'(cw_data), 32'd0);
    chk("rst_valid", 32'(cw_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_err_cnt), 32'd0);
    chk("rst_stats", 32'({overrun, drop_cnt}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(8'h96, 1'b1, 1'b1);
    chk("t6_after_rst", 32'(cw_data), 32'h96);
    idle(1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic gap;
      gap = ($urandom_range(0, 99) < 2);
      if (gap) idle($urandom_range(1, TO + 1), 1'($urandom_range(0, 1)));
      else step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 63) == 0));
    end
    idle(TO + 3, 1'b1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_cw_deserializer.md
Name: hamming_cw_deserializer

Overview:
Serial-to-parallel front end for the Hamming SECDED decoder. It collects codeword bits from a bit-serial channel, with start-of-frame marking, inter-bit timeout and framing-error detection. Each complete codeword is held in a one-entry valid/ready output buffer that feeds the decoder's 8-bit codeword input. The block also keeps saturating statistics for aborted and dropped frames.

Parameters:
CW_WIDTH, 8, codeword width in bits (minimum 2).
TIMEOUT, 255, maximum idle cycles between accepted bits inside a frame (minimum 1).
CNT_WIDTH, 8, width of the statistics counters.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
bit_in  input  1  serial codeword bit; sampled only when bit_valid=1
bit_valid  input  1  bit strobe, one bit per cycle when high
sof  input  1  start of frame; meaningful only with bit_valid=1; marks bit 0
clr_stats  input  1  synchronous clear of overrun, frame_err_cnt and drop_cnt
cw_data  output  CW_WIDTH  assembled codeword; bit i is the i-th received bit (LSB first)
cw_valid  output  1  cw_data holds an unconsumed codeword
cw_ready  input  1  downstream accepts cw_data when cw_valid&&cw_ready
busy  output  1  high while a frame is being assembled (state SHIFT)
overrun  output  1  sticky; set when a completed codeword is dropped
frame_err_cnt  output  CNT_WIDTH  saturating count of aborted frames
drop_cnt  output  CNT_WIDTH  saturating count of codewords dropped on a full buffer

Behaviour:
- Reset (async, active-high): state IDLE, shift register 0, bit index 0, timer 0, cw_data 0, cw_valid 0, busy 0, overrun 0, both counters 0. Reset mid-frame discards the partial frame.
- State IDLE:
  - bit_valid&&sof: store bit_in at index 0, set index=1, clear the timer, go to SHIFT.
  - bit_valid without sof: bit ignored, no count.
- State SHIFT:
  - bit_valid&&!sof: store bit_in at the current index, increment the index, clear the timer.
  - bit_valid&&sof: abort the partial frame, frame_err_cnt+1, restart with this bit as bit 0 (index=1), stay in SHIFT.
  - bit_valid=0: timer+1. When the timer reaches TIMEOUT, abort: frame_err_cnt+1, return to IDLE, discard partial data. Timer width is clog2(TIMEOUT+1).
  - Completion: the edge that accepts bit CW_WIDTH-1 returns the state to IDLE and presents the codeword to the output buffer.
- busy = (state == SHIFT).
- Output buffer (one entry):
  - On completion, if cw_valid=0, or cw_valid&&cw_ready in the same cycle, load cw_data and set cw_valid=1. cw_valid is visible the cycle after the edge that accepted the last bit.
  - If cw_valid=1 and cw_ready=0 on completion: drop the new codeword, keep the held data, drop_cnt+1, set overrun=1.
  - cw_valid&&cw_ready with no completion: cw_valid=0 next cycle; cw_data retains its last value.
  - cw_data is stable while cw_valid&&!cw_ready.
- Counters saturate at all-ones and never wrap.
- clr_stats clears overrun and both counters on the next edge; clear wins over a simultaneous increment or set. clr_stats does not affect frame assembly or the buffer.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. TIMEOUT=255, cw_ready=1; send 0xB4 LSB-first (0,0,1,0,1,1,0,1) with sof on the first bit -> cw_valid=1, cw_data=0xB4 one cycle after the 8th bit; cw_valid=0 the following cycle; busy high for exactly the frame duration.
2. cw_ready=0; send 0x3C then 0xA5 -> cw_data stays 0x3C, drop_cnt=1, overrun=1; raise cw_ready for one cycle -> cw_valid=0, cw_data still reads 0x3C.
3. Buffer holds 0x3C; cw_ready=1 in the same cycle the last bit of 0x5A is accepted -> next cycle cw_valid=1, cw_data=0x5A, drop_cnt unchanged.
4. sof with 3 bits, then sof plus the 8 bits of 0x81 -> frame_err_cnt=1, cw_data=0x81, no drop.
5. TIMEOUT=4; sof plus 5 bits, then 4 idle cycles -> frame_err_cnt=1, busy=0, no cw_valid; 3 more bits without sof are ignored (busy stays 0).
6. CNT_WIDTH=2; 5 aborted frames -> frame_err_cnt=3 (saturated); clr_stats -> 0; assert rst mid-frame -> all outputs 0 immediately; next full frame decodes correctly.
